// File: rtl/multimode_shift_register.sv
// Multi-mode shift register: holds an MSB-bit word and shifts it one bit per clock
// for i_amt steps (LSL/LSR/ASR/ROL/ROR), with a busy/done handshake to the datapath.
module multimode_shift_register #(
  parameter int MSB   = 16,
  parameter int AMT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [MSB-1:0]   din,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_sin,
  output logic [MSB-1:0]   dout,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       mode_q;

  // One single-bit step; result is {bit shifted out, new word}. Hold modes keep both.
  function automatic logic [MSB:0] shift_step(input logic [2:0]     mode,
                                              input logic [MSB-1:0] d,
                                              input logic           sin,
                                              input logic           sout);
    logic [MSB:0] r;
    case (mode)
      3'd0:    r = {d[MSB-1], d[MSB-2:0], sin};
      3'd1:    r = {d[0], sin, d[MSB-1:1]};
      3'd2:    r = {d[0], d[MSB-1], d[MSB-1:1]};
      3'd3:    r = {d[MSB-1], d[MSB-2:0], d[MSB-1]};
      3'd4:    r = {d[0], d[0], d[MSB-1:1]};
      default: r = {sout, d};
    endcase
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= '0;
      dout   <= '0;
      o_sout <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_clr) begin
        // Abort: no done pulse follows a cleared operation.
        state  <= IDLE;
        cnt    <= '0;
        dout   <= '0;
        o_sout <= 1'b0;
        o_busy <= 1'b0;
      end else if (state == SHIFT) begin
        {o_sout, dout} <= shift_step(mode_q, dout, i_sin, o_sout);
        cnt            <= cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end else if (i_load) begin
        dout <= din;
      end else if (i_start) begin
        mode_q <= i_mode;
        if (i_amt == '0) begin
          o_done <= 1'b1;
        end else begin
          cnt    <= i_amt;
          state  <= SHIFT;
          o_busy <= 1'b1;
        end
      end
    end
  end

endmodule
